// File: rtl/tts_pkg.sv
// Shared types and reset values for the debounced T-pulse source.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } tts_state_e;

  localparam logic T_RST      = 1'b0;
  localparam logic STABLE_RST = 1'b0;

endpackage

// File: rtl/tff_toggle_source_if.sv
// Button-side bundle: raw button level in, toggle pulse and debounced level out.
interface tff_toggle_source_if;

  logic BTN;
  logic T;
  logic STABLE;

  modport master (output BTN, input T, input STABLE);
  modport slave  (input BTN, output T, output STABLE);

endinterface

// File: rtl/tts_sync.sv
// SYNC_STAGES-deep synchronizer for an asynchronous single-bit input.
module tts_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
  // NOTE: the chain is cleared on reset so a stale high cannot skip the debounce after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_chain <= '0;
    else        r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/tff_toggle_source.sv
// Debounces a raw push-button into a one-cycle T pulse and a clean level.
// Optional auto-repeat while held is enabled by defining TTS_AUTOREPEAT_EN.
module tff_toggle_source
  import tts_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  tff_toggle_source_if.slave  bus
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2)
  begin : g_param_check
    $error("tff_toggle_source: parameter out of legal range");
  end

  logic w_btn_s;

  tts_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .i_d   (bus.BTN),
    .o_q   (w_btn_s)
  );

  tts_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic          r_t,     w_t_nxt;
  logic          r_stable, w_stable_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_state_nxt = w_btn_s ? PRESS_WAIT : IDLE;
        w_cnt_nxt   = w_btn_s ? CW'(1) : '0;
      end
      PRESS_WAIT: begin
        if (!w_btn_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!w_btn_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (w_btn_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef TTS_AUTOREPEAT_EN
  localparam int            RW       = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rep, w_rep_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_rep <= '0;
    else        r_rep <= w_rep_nxt;
  end
`endif

  always_comb begin
    w_stable_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
    w_t_nxt      = (r_state == PRESS_WAIT) && (w_state_nxt == PRESSED);
`ifdef TTS_AUTOREPEAT_EN
    w_rep_nxt    = r_rep;
    // Only cycles that stay in PRESSED advance the repeat timer; leaving never fires it.
    if (w_state_nxt == PRESSED && r_state != PRESSED) begin
      w_rep_nxt = '0;
    end else if (r_state == PRESSED && w_state_nxt == PRESSED) begin
      if (r_rep >= REP_LAST) begin
        w_rep_nxt = '0;
        w_t_nxt   = 1'b1;
      end else begin
        w_rep_nxt = r_rep + RW'(1);
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_t      <= T_RST;
      r_stable <= STABLE_RST;
    end else begin
      r_t      <= w_t_nxt;
      r_stable <= w_stable_nxt;
    end
  end

  assign bus.T      = r_t;
  assign bus.STABLE = r_stable;

endmodule

// File: tb/tb_tff_toggle_source.sv
// Directed bench for tff_toggle_source at default parameters; covers the
// auto-repeat build when TTS_AUTOREPEAT_EN is defined for the compile.
module tb_tff_toggle_source;

  logic CLK;
  logic RST_N;
  int   n_checks;
  int   n_errors;
  logic r_q;

  tff_toggle_source_if bus ();

  tff_toggle_source #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (8)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Downstream T flip-flop the pulse is meant to drive.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     r_q <= 1'b0;
    else if (bus.T) r_q <= ~r_q;
  end

  bit rel_pat [16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST_N   = 1'b0;
    bus.BTN = 1'b0;
    #1;
    check({tag, "_rst_T"}, 32'(bus.T), 0);
    check({tag, "_rst_STABLE"}, 32'(bus.STABLE), 0);
    repeat (2) tick();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Held press from edge 0 of the current cycle: T only after edge 5, STABLE from edge 5.
  task automatic press_edges(input string tag, input int n);
    for (int e = 0; e < n; e++) begin
      tick();
      check($sformatf("%s_T_e%0d", tag, e), 32'(bus.T), 32'(e == 5));
      check($sformatf("%s_STABLE_e%0d", tag, e), 32'(bus.STABLE), 32'(e >= 5));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    RST_N    = 1'b0;
    bus.BTN  = 1'b0;

    // Clean press then clean release.
    do_reset("t1");
    bus.BTN = 1'b1;
    press_edges("t1", 10);
    @(negedge CLK);
    bus.BTN = 1'b0;
    for (int r = 0; r < 8; r++) begin
      tick();
      check($sformatf("t1_rel_T_r%0d", r), 32'(bus.T), 0);
      check($sformatf("t1_rel_STABLE_r%0d", r), 32'(bus.STABLE), 32'(r < 5));
    end

    // Three-cycle glitch is rejected.
    do_reset("t2");
    for (int e = 0; e < 12; e++) begin
      bus.BTN = (e < 3);
      tick();
      check($sformatf("t2_T_e%0d", e), 32'(bus.T), 0);
      check($sformatf("t2_STABLE_e%0d", e), 32'(bus.STABLE), 0);
      @(negedge CLK);
    end

    // Press, then release with two-cycle high bounces.
    do_reset("t3");
    bus.BTN = 1'b1;
    press_edges("t3", 8);
    for (int r = 0; r < 16; r++) begin
      @(negedge CLK);
      bus.BTN = rel_pat[r];
      tick();
      check($sformatf("t3_T_r%0d", r), 32'(bus.T), 0);
      check($sformatf("t3_STABLE_r%0d", r), 32'(bus.STABLE), 32'(r < 12));
    end

    // Reset in PRESSED with the button still held, then a full new debounce.
    do_reset("t4");
    bus.BTN = 1'b1;
    press_edges("t4a", 8);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("t4_async_T", 32'(bus.T), 0);
    check("t4_async_STABLE", 32'(bus.STABLE), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    press_edges("t4b", 8);

    // Long hold: one pulse, or a pulse every 8 cycles with auto-repeat.
    do_reset("t5");
    bus.BTN = 1'b1;
    for (int e = 0; e < 40; e++) begin
      logic exp_t;
`ifdef TTS_AUTOREPEAT_EN
      exp_t = (e >= 5) && (((e - 5) % 8) == 0);
`else
      exp_t = (e == 5);
`endif
      tick();
      check($sformatf("t5_T_e%0d", e), 32'(bus.T), 32'(exp_t));
      check($sformatf("t5_STABLE_e%0d", e), 32'(bus.STABLE), 32'(e >= 5));
    end
    @(negedge CLK);
    bus.BTN = 1'b0;
    for (int r = 0; r < 10; r++) begin
      tick();
      check($sformatf("t5_rel_T_r%0d", r), 32'(bus.T), 0);
      check($sformatf("t5_rel_STABLE_r%0d", r), 32'(bus.STABLE), 32'(r < 5));
    end

    // Three presses into a T flip-flop starting at Q=0.
    do_reset("t6");
    check("t6_q_init", 32'(r_q), 0);
    for (int p = 0; p < 3; p++) begin
      bus.BTN = 1'b1;
      repeat (10) tick();
      @(negedge CLK);
      bus.BTN = 1'b0;
      repeat (10) tick();
      check($sformatf("t6_q_p%0d", p), 32'(r_q), 32'((p % 2) == 0));
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
